// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS main controller (IF/ID/EX/MEM/WB) with cycle and retired-instruction counters
// Inputs : clk, rst (async, active-high), Mem_ready, opcode/funct (IR fields), Zero (ALU flag)
// Outputs: ALUop, ALUSrcA/B, PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, RegWrite,
//          RegDst, MemtoReg, state_o, cycle_cnt, inst_cnt
module mips_mc_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Mem_ready,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 Zero,
    output logic [2:0]           ALUop,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic                 PCWrite,
    output logic [1:0]           PCSource,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] inst_cnt
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
    state_t r_state, w_next;
    logic w_rtype, w_sll, w_jr, w_r_alu, w_i_alu, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_br, w_valid;
    logic [2:0] w_rop, w_iop;
    assign w_rtype = opcode == 6'h00;
    assign w_sll   = w_rtype && funct == 6'h00;
    assign w_jr    = w_rtype && funct == 6'h08;
    assign w_r_alu = w_rtype && (funct inside {6'h00, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b});
    assign w_rop   = funct == 6'h21 ? 3'b010 : funct == 6'h23 ? 3'b110 : funct == 6'h24 ? 3'b000 :
                     funct == 6'h25 ? 3'b001 : funct == 6'h2a ? 3'b111 : funct == 6'h2b ? 3'b011 : 3'b100;
    assign w_i_alu = opcode inside {6'h09, 6'h0a, 6'h0b, 6'h0f};
    assign w_iop   = opcode == 6'h09 ? 3'b010 : opcode == 6'h0a ? 3'b111 : opcode == 6'h0b ? 3'b011 : 3'b101;
    assign w_lw    = opcode == 6'h23;
    assign w_sw    = opcode == 6'h2b;
    assign w_beq   = opcode == 6'h04;
    assign w_bne   = opcode == 6'h05;
    assign w_j     = opcode == 6'h02;
    assign w_jal   = opcode == 6'h03;
    assign w_br    = w_beq || w_bne;
    assign w_valid = w_r_alu || w_jr || w_i_alu || w_lw || w_sw || w_br || w_j || w_jal;
    assign state_o = r_state;
    // Outputs are decoded from the current state plus same-cycle Mem_ready/Zero,
    // and forced to their idle values while rst is held.
    always_comb begin
        ALUop    = 3'b010;
        ALUSrcA  = 2'd0;
        ALUSrcB  = 2'd0;
        PCWrite  = 1'b0;
        PCSource = 2'd0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        MemtoReg = 2'd0;
        w_next   = r_state;
        if (!rst) begin
            case (r_state)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'd1;
                    IRWrite = Mem_ready;
                    PCWrite = Mem_ready;
                    w_next  = Mem_ready ? S_ID : S_IF;
                end
                S_ID: begin
                    ALUSrcB  = 2'd3;
                    PCWrite  = w_j || w_jr;
                    PCSource = w_j ? 2'd2 : w_jr ? 2'd3 : 2'd0;
                    w_next   = w_jal ? S_WB : (w_j || w_jr || !w_valid) ? S_IF : S_EX;
                end
                S_EX: begin
                    ALUSrcA  = w_sll ? 2'd2 : 2'd1;
                    ALUSrcB  = (w_r_alu || w_br) ? 2'd0 : 2'd2;
                    ALUop    = w_r_alu ? w_rop : w_i_alu ? w_iop : w_br ? 3'b110 : 3'b010;
                    PCSource = w_br ? 2'd1 : 2'd0;
                    PCWrite  = w_beq ? Zero : (w_bne && !Zero);
                    w_next   = (w_lw || w_sw) ? S_MEM : (w_r_alu || w_i_alu) ? S_WB : S_IF;
                end
                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = w_lw;
                    MemWrite = w_sw;
                    w_next   = !Mem_ready ? S_MEM : w_lw ? S_WB : S_IF;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = w_jal ? 2'd2 : {1'b0, w_r_alu};
                    MemtoReg = w_jal ? 2'd2 : {1'b0, w_lw};
                    PCWrite  = w_jal;
                    PCSource = w_jal ? 2'd2 : 2'd0;
                    w_next   = S_IF;
                end
                default: w_next = S_IF;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IF;
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            r_state   <= w_next;
            cycle_cnt <= cycle_cnt + 1'b1;
            if (r_state != S_IF && w_next == S_IF)
                inst_cnt <= inst_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: scoreboard bench for the multi-cycle controller
module tb_mips_mc_ctrl;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_JR = 7, K_JAL = 8, K_NOP = 9;
    typedef struct packed {logic mr; logic [21:0] e;} ent_t;
    logic clk = 1'b0, rst, Mem_ready, Zero;
    logic [5:0] opcode, funct;
    logic [2:0] ALUop, state_o;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg;
    logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [31:0] cycle_cnt, inst_cnt;
    logic [2:0] w_op, w_st, w_cyc, w_inst;
    logic [1:0] w_sa, w_sb, w_ps, w_rd, w_m2r;
    logic w_pw, w_iord, w_mr, w_mw, w_irw, w_rw;
    logic [21:0] obs;
    ent_t q[$];
    int n_vec = 0, n_err = 0;
    always #5 clk = ~clk;
    mips_mc_ctrl #(.CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .Mem_ready(Mem_ready), .opcode(opcode), .funct(funct), .Zero(Zero),
        .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCWrite(PCWrite), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .state_o(state_o), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );
    mips_mc_ctrl #(.CNT_WIDTH(3)) u_wrap (
        .clk(clk), .rst(rst), .Mem_ready(1'b1), .opcode(6'h3f), .funct(6'h00), .Zero(1'b0),
        .ALUop(w_op), .ALUSrcA(w_sa), .ALUSrcB(w_sb), .PCWrite(w_pw), .PCSource(w_ps),
        .IorD(w_iord), .MemRead(w_mr), .MemWrite(w_mw), .IRWrite(w_irw), .RegWrite(w_rw),
        .RegDst(w_rd), .MemtoReg(w_m2r), .state_o(w_st), .cycle_cnt(w_cyc), .inst_cnt(w_inst)
    );
    assign obs = {state_o, ALUop, ALUSrcA, ALUSrcB, PCWrite, PCSource, IorD, MemRead, MemWrite,
                  IRWrite, RegWrite, RegDst, MemtoReg};
    function automatic logic [21:0] mk(input int s, op, a, b, pw, ps, iord, mr, mw, irw, rw, rd, m2r);
        return {s[2:0], op[2:0], a[1:0], b[1:0], pw[0], ps[1:0], iord[0], mr[0], mw[0], irw[0], rw[0], rd[1:0], m2r[1:0]};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic push(input logic mr, input logic [21:0] e);
        q.push_back({mr, e});
    endtask
    task automatic exec(input string tag, input logic [5:0] op, input logic [5:0] fn, input int k,
                        input int eop, input int esa, input logic z, input int wi, input int wm);
        logic [31:0] c0, i0;
        int n;
        ent_t e;
        for (int i = 0; i < wi; i++) push(1'b0, mk(0, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        push(1'b1, mk(0, 2, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
        push($urandom_range(0, 1) == 1, mk(1, 2, 0, 3, int'(k == K_J || k == K_JR), k == K_J ? 2 : k == K_JR ? 3 : 0, 0, 0, 0, 0, 0, 0, 0));
        if (k == K_R || k == K_I) begin
            push($urandom_range(0, 1) == 1, mk(2, eop, esa, k == K_R ? 0 : 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            push($urandom_range(0, 1) == 1, mk(4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, k == K_R ? 1 : 0, 0));
        end
        if (k == K_LW || k == K_SW) begin
            push($urandom_range(0, 1) == 1, mk(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            for (int i = 0; i < wm; i++) push(1'b0, mk(3, 2, 0, 0, 0, 0, 1, int'(k == K_LW), int'(k == K_SW), 0, 0, 0, 0));
            push(1'b1, mk(3, 2, 0, 0, 0, 0, 1, int'(k == K_LW), int'(k == K_SW), 0, 0, 0, 0));
            if (k == K_LW) push($urandom_range(0, 1) == 1, mk(4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        end
        if (k == K_BEQ || k == K_BNE)
            push($urandom_range(0, 1) == 1, mk(2, 6, 1, 0, k == K_BEQ ? int'(z) : int'(!z), 1, 0, 0, 0, 0, 0, 0, 0));
        if (k == K_JAL) push($urandom_range(0, 1) == 1, mk(4, 2, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2, 2));
        n = q.size();
        c0 = cycle_cnt;
        i0 = inst_cnt;
        opcode = op;
        funct = fn;
        Zero = z;
        while (q.size() > 0) begin
            e = q.pop_front();
            Mem_ready = e.mr;
            #1;
            check(tag, {10'd0, obs}, {10'd0, e.e});
            @(negedge clk);
        end
        check({tag, "_cyc"}, cycle_cnt - c0, n);
        check({tag, "_inst"}, inst_cnt - i0, 32'd1);
    endtask
    initial begin
        rst = 1'b1;
        Mem_ready = 1'b1;
        Zero = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        repeat (2) @(negedge clk);
        check("rst_out", {10'd0, obs}, {10'd0, mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        rst = 1'b0;
        check("rst_cyc", cycle_cnt, 32'd0);
        check("rst_inst", inst_cnt, 32'd0);
        exec("addu", 6'h00, 6'h21, K_R, 2, 1, 1'b0, 0, 0);
        exec("addu_w", 6'h00, 6'h21, K_R, 2, 1, 1'b1, 2, 0);
        exec("subu", 6'h00, 6'h23, K_R, 6, 1, 1'b0, 0, 0);
        exec("and", 6'h00, 6'h24, K_R, 0, 1, 1'b0, 0, 0);
        exec("or", 6'h00, 6'h25, K_R, 1, 1, 1'b0, 0, 0);
        exec("slt", 6'h00, 6'h2a, K_R, 7, 1, 1'b0, 0, 0);
        exec("sltu", 6'h00, 6'h2b, K_R, 3, 1, 1'b0, 0, 0);
        exec("sll", 6'h00, 6'h00, K_R, 4, 2, 1'b0, 0, 0);
        exec("jr", 6'h00, 6'h08, K_JR, 0, 0, 1'b0, 0, 0);
        exec("addiu", 6'h09, 6'h15, K_I, 2, 1, 1'b0, 0, 0);
        exec("slti", 6'h0a, 6'h00, K_I, 7, 1, 1'b0, 0, 0);
        exec("sltiu", 6'h0b, 6'h2a, K_I, 3, 1, 1'b0, 0, 0);
        exec("lui", 6'h0f, 6'h00, K_I, 5, 1, 1'b0, 0, 0);
        exec("lw_w3", 6'h23, 6'h00, K_LW, 0, 0, 1'b0, 0, 3);
        exec("lw", 6'h23, 6'h08, K_LW, 0, 0, 1'b1, 1, 0);
        exec("sw", 6'h2b, 6'h00, K_SW, 0, 0, 1'b0, 0, 1);
        exec("beq_z1", 6'h04, 6'h00, K_BEQ, 0, 0, 1'b1, 0, 0);
        exec("beq_z0", 6'h04, 6'h00, K_BEQ, 0, 0, 1'b0, 0, 0);
        exec("bne_z1", 6'h05, 6'h00, K_BNE, 0, 0, 1'b1, 0, 0);
        exec("bne_z0", 6'h05, 6'h00, K_BNE, 0, 0, 1'b0, 0, 0);
        exec("j", 6'h02, 6'h00, K_J, 0, 0, 1'b0, 0, 0);
        exec("jal", 6'h03, 6'h00, K_JAL, 0, 0, 1'b0, 0, 0);
        exec("bad_op", 6'h3f, 6'h00, K_NOP, 0, 0, 1'b0, 0, 0);
        exec("bad_fn", 6'h00, 6'h3f, K_NOP, 0, 0, 1'b0, 0, 0);
        opcode = 6'h2b;
        Mem_ready = 1'b1;
        @(negedge clk);
        Mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("sw_mem", {10'd0, obs}, {10'd0, mk(3, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0)});
        rst = 1'b1;
        #1;
        check("rst_mid", {10'd0, obs}, {10'd0, mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        check("rst_mid_inst", inst_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rel_cyc", cycle_cnt, 32'd0);
        exec("sw_after", 6'h2b, 6'h00, K_SW, 0, 0, 1'b0, 1, 0);
        check("rel_inst", inst_cnt, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        check("wrap_cyc7", {29'd0, w_cyc}, 32'd7);
        @(negedge clk);
        check("wrap_cyc0", {29'd0, w_cyc}, 32'd0);
        repeat (6) @(negedge clk);
        check("wrap_inst7", {29'd0, w_inst}, 32'd7);
        repeat (2) @(negedge clk);
        check("wrap_inst0", {29'd0, w_inst}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
